noise_sampler: RTL and testbench
================================

# noise_sampler

Consumes the `coin` produced by the pre-encryption hash stage and generates all CBD noise polynomials needed by K-PKE encryption: vector r (K polys, ETA1), vector e1 (K polys, ETA2) and scalar e2 (1 poly, ETA2). For each polynomial it issues one PRF request (SHAKE-256 of coin‖nonce) to the shared PRF core over a req/ready handshake and captures the returned byte string. It then streams 256 centered-binomial coefficients, reduced to [0, KYBER_Q), to the NTT/encrypt stage over a valid/ready interface.

## Interface
- `KYBER_N`, 256: coefficients per polynomial.
- `KYBER_K`, 3: module rank; total polynomials = 2·KYBER_K+1.
- `KYBER_Q`, 3329: modulus.
- `ETA`, 2: CBD parameter, used for all polynomials (ETA1 = ETA2 = ETA).
- `PRF_W`, 512·ETA: PRF output width in bits (64·ETA bytes).

Ports:
- `clk` input 1: clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin sampling. Sampled only in IDLE.
- `coin` input 256: seed r from pre-encryption. Latched on accepted start.
- `prf_req` output 1: PRF request valid.
- `prf_seed` output 256: latched coin.
- `prf_nonce` output 8: nonce for this request (= polynomial index).
- `prf_ready` input 1: PRF core accepts request.
- `prf_valid` input 1: PRF output valid, one-cycle pulse.
- `prf_data` input PRF_W: PRF output. Byte 0 is in [7:0]; bit j of the byte stream is `prf_data[j]`.
- `coef_valid` output 1: coefficient valid.
- `coef` output 12: coefficient in [0, KYBER_Q).
- `coef_ready` input 1: downstream accepts.
- `poly_idx` output 4: current polynomial, 0..2K.
- `coef_idx` output 8: current coefficient, 0..255.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse after the last coefficient of poly 2K transfers.

## Operation
- States: IDLE → REQ → WAIT → EMIT → (REQ | DONE) → IDLE.
- **IDLE**
  - On `start`: latch `coin`, set poly_idx=0 and coef_idx=0, go to REQ.
  - `start` is ignored in all other states.
- **REQ**
  - `prf_req`=1, with `prf_nonce`=poly_idx and `prf_seed` stable.
  - On `prf_req && prf_ready`: go to WAIT and drop `prf_req` next cycle.
- **WAIT**
  - On `prf_valid`: register `prf_data` into an internal buffer and go to EMIT.
  - `prf_valid` outside WAIT is ignored.
- **EMIT**
  - Coefficient i = coef_idx.
  - a = popcount(buf[2·ETA·i +: ETA]).
  - b = popcount(buf[2·ETA·i+ETA +: ETA]).
  - d = a−b in [−ETA, ETA]; `coef` = d if d ≥ 0, else KYBER_Q+d.
  - `coef_valid`=1. On `coef_valid && coef_ready`, coef_idx increments.
  - When coef_idx=255 transfers:
    - if poly_idx<2K: poly_idx++, coef_idx←0, go to REQ;
    - else go to DONE.
- **DONE**: `done`=1 for one cycle, then IDLE. poly_idx and coef_idx hold their last values.
- Polynomial order:
  - nonce 0..K−1 = r;
  - nonce K..2K−1 = e1;
  - nonce 2K = e2.
- Backpressure: while `coef_ready`=0, `coef`, `coef_idx` and `poly_idx` stay stable.
- Reset (any state, including mid-EMIT or while `prf_req` is pending):
  - state=IDLE;
  - `prf_req`, `coef_valid`, `done`, `busy` = 0;
  - `coef`, `coef_idx`, `poly_idx`, `prf_nonce`, `prf_seed` and the buffer = 0.

## Timing
- Reset values: every output is 0.
- `start` accepted in cycle t → `prf_req`=1 in cycle t+1.
- `prf_valid` in cycle t → first `coef_valid` in cycle t+1.
- With `coef_ready` held high, one coefficient transfers per cycle: 256 cycles per polynomial.
- Last-coefficient transfer in cycle t:
  - next poly: `prf_req`=1 in t+1;
  - final poly: `done`=1 in t+1, IDLE in t+2.
- `busy` rises the cycle after `start` and falls when `done` falls.
- Minimum total latency with zero PRF latency: about 7·(256+2)+2 cycles for K=3.
- Same-cycle `start` and `rst`: reset wins.

## Test plan
- **All-zero PRF data:** `prf_data`=0 for every request → 7×256 coefficients all 0, nonces 0..6 in order, `done` pulses exactly once.
- **Repeating bytes 0xC3:**
  - even coef_idx (nibble 0x3: a=2, b=0) = 2;
  - odd coef_idx (nibble 0xC: a=0, b=2) = 3327.
- **Other nibbles:**
  - repeating 0x41 → even = 1, odd = 3328;
  - all-ones → all coefficients 0.
- **Backpressure:** toggle `coef_ready` pseudo-randomly and hold `prf_ready`=0 for 5 cycles → `prf_req` stays high and `prf_nonce` stable; `coef`/`coef_idx` hold while not ready; no coefficient is lost or duplicated (check against a reference model).
- **Reset mid-operation:** assert `rst` during EMIT of poly 3, coef_idx 100 → next cycle all outputs 0 and state IDLE. A fresh `start` restarts at nonce 0 with the new coin.
- **Spurious inputs:**
  - `start` while busy is ignored and poly order is unchanged;
  - a `prf_valid` pulse during EMIT does not alter the buffer or the output coefficients.

Source files
------------

// File: rtl/noise_sampler.sv
// noise_sampler: requests one PRF output per noise polynomial (r, e1, e2)
// and streams centered-binomial coefficients reduced into [0, KYBER_Q).
module noise_sampler #(
  parameter int KYBER_N = 256,
  parameter int KYBER_K = 3,
  parameter int KYBER_Q = 3329,
  parameter int ETA     = 2,
  parameter int PRF_W   = 512 * ETA
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [255:0]     coin,
  output logic             prf_req,
  output logic [255:0]     prf_seed,
  output logic [7:0]       prf_nonce,
  input  logic             prf_ready,
  input  logic             prf_valid,
  input  logic [PRF_W-1:0] prf_data,
  output logic             coef_valid,
  output logic [11:0]      coef,
  input  logic             coef_ready,
  output logic [3:0]       poly_idx,
  output logic [7:0]       coef_idx,
  output logic             busy,
  output logic             done
);

  localparam int         BW        = $clog2(PRF_W);
  localparam int         CNT_W     = $clog2(ETA + 1);
  localparam logic [7:0] LAST_COEF = 8'(KYBER_N - 1);
  localparam logic [3:0] LAST_POLY = 4'(2 * KYBER_K);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [PRF_W-1:0] sample_buf;
  logic [BW-1:0]    bit_base;
  logic [2*ETA-1:0] pair;
  logic [CNT_W-1:0] pop_a;
  logic [CNT_W-1:0] pop_b;
  logic             emit_xfer;
  logic             last_coef;
  logic             more_polys;

  assign emit_xfer  = (state == S_EMIT) && coef_ready;
  assign last_coef  = (coef_idx == LAST_COEF);
  assign more_polys = (poly_idx < LAST_POLY);

  assign prf_req    = (state == S_REQ);
  assign prf_nonce  = {4'b0000, poly_idx};
  assign coef_valid = (state == S_EMIT);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  // State register; reset returns to IDLE and overrides a simultaneous start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one request, one capture, then KYBER_N coefficients per polynomial.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start)     state_next = S_REQ;
      S_REQ:  if (prf_ready) state_next = S_WAIT;
      S_WAIT: if (prf_valid) state_next = S_EMIT;
      S_EMIT: begin
        if (emit_xfer && last_coef) begin
          state_next = more_polys ? S_REQ : S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Seed latch, PRF capture and polynomial/coefficient counters; indices hold through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      prf_seed   <= '0;
      sample_buf <= '0;
      poly_idx   <= '0;
      coef_idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            prf_seed <= coin;
            poly_idx <= '0;
            coef_idx <= '0;
          end
        end
        S_WAIT: begin
          if (prf_valid) sample_buf <= prf_data;
        end
        S_EMIT: begin
          if (coef_ready) begin
            if (last_coef) begin
              if (more_polys) begin
                poly_idx <= poly_idx + 4'd1;
                coef_idx <= '0;
              end
            end else begin
              coef_idx <= coef_idx + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // CBD sample: popcount of the low ETA bits minus popcount of the high ETA bits, folded mod q.
  always_comb begin
    bit_base = BW'(coef_idx) * BW'(2 * ETA);
    pair     = sample_buf[bit_base +: 2*ETA];
    pop_a    = '0;
    pop_b    = '0;
    for (int j = 0; j < ETA; j++) begin
      pop_a = pop_a + CNT_W'(pair[j]);
      pop_b = pop_b + CNT_W'(pair[ETA + j]);
    end
    if (state != S_EMIT) begin
      coef = '0;
    end else if (pop_a >= pop_b) begin
      coef = 12'(pop_a - pop_b);
    end else begin
      coef = 12'(KYBER_Q) - 12'(pop_b - pop_a);
    end
  end

endmodule

// File: tb/tb_noise_sampler.sv
// tb_noise_sampler: scoreboard bench with a PRF responder model, a coefficient
// monitor and a stimulus sequencer covering data patterns, backpressure and reset.
module tb_noise_sampler;

  localparam int ETA   = 2;
  localparam int PRF_W = 512 * ETA;
  localparam int NPOLY = 7;
  localparam int Q     = 3329;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [255:0]     coin;
  logic             prf_req;
  logic [255:0]     prf_seed;
  logic [7:0]       prf_nonce;
  logic             prf_ready;
  logic             prf_valid;
  logic [PRF_W-1:0] prf_data;
  logic             coef_valid;
  logic [11:0]      coef;
  logic             coef_ready;
  logic [3:0]       poly_idx;
  logic [7:0]       coef_idx;
  logic             busy;
  logic             done;

  typedef struct {
    int poly;
    int idx;
    int value;
  } exp_t;

  exp_t             sb[$];
  int               errors     = 0;
  int               checks     = 0;
  int               mode       = 0;
  int               req_hold   = 0;
  bit               bp_en      = 1'b0;
  bit               spur_en    = 1'b0;
  logic [255:0]     exp_coin   = '0;
  int               exp_nonce  = 0;
  int               done_count = 0;
  logic [PRF_W-1:0] prf_d;

  noise_sampler dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .coin       (coin),
    .prf_req    (prf_req),
    .prf_seed   (prf_seed),
    .prf_nonce  (prf_nonce),
    .prf_ready  (prf_ready),
    .prf_valid  (prf_valid),
    .prf_data   (prf_data),
    .coef_valid (coef_valid),
    .coef       (coef),
    .coef_ready (coef_ready),
    .poly_idx   (poly_idx),
    .coef_idx   (coef_idx),
    .busy       (busy),
    .done       (done)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  // Reference: coefficient i uses nibble i of the byte stream (low nibble of byte i/2 first);
  // its two low bits count +1 each, its two high bits count -1 each.
  function automatic int expCoef(input int m, input logic [PRF_W-1:0] d, input int i);
    logic [7:0] by;
    logic [3:0] nib;
    int a;
    int b;
    case (m)
      0, 3:    return 0;
      1:       return (i % 2 == 0) ? 2 : Q - 2;
      2:       return (i % 2 == 0) ? 1 : Q - 1;
      default: begin
        by  = d[8*(i/2) +: 8];
        nib = (i % 2 == 0) ? by[3:0] : by[7:4];
        a   = int'(nib[0]) + int'(nib[1]);
        b   = int'(nib[2]) + int'(nib[3]);
        return (a >= b) ? a - b : Q + a - b;
      end
    endcase
  endfunction

  task automatic checkReset(input string tag);
    checkOutput({tag, "_prf_req"},    prf_req,    0);
    checkOutput({tag, "_prf_seed"},   prf_seed,   0);
    checkOutput({tag, "_prf_nonce"},  prf_nonce,  0);
    checkOutput({tag, "_coef_valid"}, coef_valid, 0);
    checkOutput({tag, "_coef"},       coef,       0);
    checkOutput({tag, "_poly_idx"},   poly_idx,   0);
    checkOutput({tag, "_coef_idx"},   coef_idx,   0);
    checkOutput({tag, "_busy"},       busy,       0);
    checkOutput({tag, "_done"},       done,       0);
  endtask

  // PRF core model: checks each request, optionally stalls it, then returns data and queues expectations
  initial begin : prf_model
    prf_ready = 1'b0;
    prf_valid = 1'b0;
    prf_data  = '0;
    forever begin
      @(negedge clk);
      prf_valid = 1'b0;
      if (prf_req) begin
        checkOutput("prf_nonce", prf_nonce, exp_nonce);
        checkOutput("prf_seed", prf_seed, exp_coin);
        for (int h = 0; h < req_hold; h++) begin
          @(negedge clk);
          checkOutput("req_hold", prf_req, 1);
          checkOutput("nonce_hold", prf_nonce, exp_nonce);
        end
        prf_ready = 1'b1;
        @(negedge clk);
        prf_ready = 1'b0;
        checkOutput("req_drop", prf_req, 0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        case (mode)
          0:       prf_d = '0;
          1:       for (int k = 0; k < PRF_W/8; k++) prf_d[8*k +: 8] = 8'hC3;
          2:       for (int k = 0; k < PRF_W/8; k++) prf_d[8*k +: 8] = 8'h41;
          3:       prf_d = '1;
          default: for (int k = 0; k < PRF_W/32; k++) prf_d[32*k +: 32] = $urandom;
        endcase
        for (int i = 0; i < 256; i++) sb.push_back('{exp_nonce, i, expCoef(mode, prf_d, i)});
        prf_data  = prf_d;
        prf_valid = 1'b1;
        exp_nonce++;
      end else if (spur_en && coef_valid && coef_idx < 8'd200 && $urandom_range(0, 30) == 0) begin
        for (int k = 0; k < PRF_W/32; k++) prf_data[32*k +: 32] = $urandom;
        prf_valid = 1'b1;
      end
    end
  end

  // Monitor: drives coef_ready, compares every presented coefficient to the queue head, pops on transfer
  initial begin : monitor
    coef_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (done) done_count++;
      coef_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (coef_valid) begin
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", 1, 0);
        end else begin
          checkOutput("poly_idx", poly_idx, sb[0].poly);
          checkOutput("coef_idx", coef_idx, sb[0].idx);
          checkOutput("coef", coef, sb[0].value);
          if (coef_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input int m, input bit bp, input bit spur, input logic [255:0] c);
    int cyc;
    bit seen;
    cyc        = 0;
    seen       = 1'b0;
    mode       = m;
    bp_en      = bp;
    spur_en    = spur;
    req_hold   = bp ? 5 : 0;
    exp_coin   = c;
    exp_nonce  = 0;
    done_count = 0;
    @(negedge clk);
    coin  = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    coin  = rand256();
    checkOutput("req_after_start", prf_req, 1);
    checkOutput("busy_rise", busy, 1);
    while (!seen && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        seen  = 1'b1;
        start = 1'b0;
      end else begin
        start = spur && ($urandom_range(0, 15) == 0);
        if (start) coin = rand256();
      end
    end
    start = 1'b0;
    if (!seen) checkOutput("done_timeout", 0, 1);
    @(negedge clk);
    checkOutput("done_one_cycle", done, 0);
    checkOutput("busy_fall", busy, 0);
    @(negedge clk);
    checkOutput("done_count", done_count, 1);
    checkOutput("sb_empty", sb.size(), 0);
    checkOutput("nonce_total", exp_nonce, NPOLY);
    checkOutput("poly_idx_hold", poly_idx, NPOLY - 1);
    checkOutput("coef_idx_hold", coef_idx, 255);
  endtask

  task automatic resetMidRun();
    int cyc;
    bit hit;
    cyc        = 0;
    hit        = 1'b0;
    mode       = 4;
    bp_en      = 1'b0;
    spur_en    = 1'b0;
    req_hold   = 0;
    exp_coin   = rand256();
    exp_nonce  = 0;
    done_count = 0;
    @(negedge clk);
    coin  = exp_coin;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!hit && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (coef_valid && poly_idx == 4'd3 && coef_idx == 8'd100) hit = 1'b1;
    end
    if (!hit) checkOutput("mid_timeout", 0, 1);
    rst = 1'b1;
    @(negedge clk);
    checkReset("mid");
    rst = 1'b0;
    sb.delete();
  endtask

  // Sequencer: reset (with a competing start), data patterns, backpressure, reset mid-run
  initial begin : main
    rst   = 1'b1;
    start = 1'b1;
    coin  = rand256();
    repeat (3) @(negedge clk);
    checkReset("por");
    rst   = 1'b0;
    start = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, rand256());
    applyStimulus(1, 1'b0, 1'b1, rand256());
    applyStimulus(2, 1'b0, 1'b0, rand256());
    applyStimulus(3, 1'b0, 1'b1, rand256());
    applyStimulus(4, 1'b1, 1'b1, rand256());
    resetMidRun();
    applyStimulus(4, 1'b1, 1'b0, rand256());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
